// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED bank scheduler.
// The optional PWM dimming path is enabled by defining LED_SCHED_PWM_EN.
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  localparam int LED_W_DEF  = 12;
  localparam int HOLD_W_DEF = 8;

  // First set bit of req at or after ptr, wrapping within n requesters.
  function automatic logic [2:0] rr_select(
    input logic [7:0] req,
    input logic [2:0] ptr,
    input int         n
  );
    logic [2:0] sel;
    logic       found;
    int         idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !found && req[idx]) begin
        sel   = 3'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/led_sched_if.sv
// Requester-side bundle of the LED scheduler.
// brightness exists only when LED_SCHED_PWM_EN is defined.
interface led_sched_if
  import led_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LED_W   = LED_W_DEF,
  parameter int HOLD_W  = HOLD_W_DEF
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*LED_W-1:0]  pattern;
  logic [NUM_REQ*HOLD_W-1:0] hold;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic                      busy;
  logic [LED_W-1:0]          led;
`ifdef LED_SCHED_PWM_EN
  logic [3:0]                brightness;

  modport master (
    output req, pattern, hold, brightness,
    input  grant, done, busy, led
  );
  modport slave (
    input  req, pattern, hold, brightness,
    output grant, done, busy, led
  );
`else
  modport master (
    output req, pattern, hold,
    input  grant, done, busy, led
  );
  modport slave (
    input  req, pattern, hold,
    output grant, done, busy, led
  );
`endif

endinterface

// File: rtl/led_scheduler_tick.sv
// Free-running display tick: one-cycle pulse every TICK_DIV clocks.
module tick_prescaler #(
  parameter int TICK_DIV = 25000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_cnt <= '0;
    else if (tick) r_cnt <= '0;
    else           r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/led_scheduler.sv
// Round-robin time-sharing of the LED bank between pattern requesters.
// Define LED_SCHED_PWM_EN to add brightness dimming of the shown pattern.
module led_scheduler
  import led_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int LED_W    = LED_W_DEF,
  parameter int TICK_DIV = 25000,
  parameter int HOLD_W   = HOLD_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  led_sched_if.slave   bus
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_sel;
  logic [2:0]          r_ptr;
  logic [2:0]          w_sel;
  logic [LED_W-1:0]    r_pat;
  logic [LED_W-1:0]    r_led;
  logic [LED_W-1:0]    w_led_nxt;
  logic [LED_W-1:0]    w_pat_in;
  logic [LED_W-1:0]    w_pat_cur;
  logic [HOLD_W-1:0]   r_cnt;
  logic [HOLD_W-1:0]   w_hold_in;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_done;
  logic [NUM_REQ-1:0]  w_grant_nxt;
  logic [NUM_REQ-1:0]  w_done_nxt;
  logic [7:0]          w_req8;
  logic                w_tick;
  logic                w_any;
  logic                w_abort;
  logic                w_last;
  logic                w_lit;
  logic                w_take;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_req8    = 8'(bus.req);
  assign w_any     = |bus.req;
  assign w_sel     = rr_select(w_req8, r_ptr, NUM_REQ);
  assign w_pat_in  = bus.pattern[int'(w_sel)*LED_W +: LED_W];
  assign w_hold_in = bus.hold[int'(w_sel)*HOLD_W +: HOLD_W];
  assign w_take    = (r_state == IDLE) && w_any;
  assign w_abort   = (r_state == SHOW) && !w_req8[r_sel];
  assign w_last    = w_tick && (r_cnt == HOLD_W'(1));

`ifdef LED_SCHED_PWM_EN
  logic [3:0] r_pwm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pwm <= '0;
    else     r_pwm <= r_pwm + 4'd1;
  end

  assign w_lit = (bus.brightness == 4'hF) ||
                 (r_pwm < bus.brightness);
`else
  assign w_lit = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_state_nxt = SHOW;
      SHOW:    if (w_abort || w_last) w_state_nxt = GAP;
      GAP:     if (w_tick) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Abort wins over a completion tick: grant drops with no done pulse.
  always_comb begin
    w_grant_nxt = '0;
    w_done_nxt  = '0;
    w_led_nxt   = '0;
    w_pat_cur   = r_pat;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt = NUM_REQ'(8'd1 << w_sel);
          w_pat_cur   = w_pat_in;
        end
      end
      SHOW: begin
        if (!w_abort) begin
          if (w_last) w_done_nxt  = r_grant;
          else        w_grant_nxt = r_grant;
        end
      end
      default: ;
    endcase
    if (w_grant_nxt != '0 && w_lit) w_led_nxt = w_pat_cur;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant <= '0;
      r_done  <= '0;
      r_led   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_pat   <= '0;
      r_cnt   <= '0;
    end else begin
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_led   <= w_led_nxt;
      if (w_take) begin
        r_sel <= w_sel;
        r_ptr <= (w_sel == 3'(NUM_REQ - 1)) ? 3'd0 : w_sel + 3'd1;
        r_pat <= w_pat_in;
        r_cnt <= (w_hold_in == '0) ? HOLD_W'(1) : w_hold_in;
      end else if (r_state == SHOW && w_tick) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign bus.grant = r_grant;
  assign bus.done  = r_done;
  assign bus.led   = r_led;
  assign bus.busy  = (r_state != IDLE);

endmodule

// File: tb/tb_led_scheduler.sv
// Directed self-checking bench for led_scheduler (TICK_DIV=4, NUM_REQ=4).
// PWM checks are compiled in when LED_SCHED_PWM_EN is defined.
module tb_led_scheduler;

  typedef struct {
    logic [3:0]  req;
    logic [11:0] pat2;
    logic [7:0]  hold2;
    logic [3:0]  grant;
    logic [11:0] led;
    logic [3:0]  done;
    logic        busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t tv[17];

  always #5 clk = ~clk;

  led_sched_if #(
    .NUM_REQ (4),
    .LED_W   (12),
    .HOLD_W  (8)
  ) bus ();

  led_scheduler #(
    .NUM_REQ  (4),
    .LED_W    (12),
    .TICK_DIV (4),
    .HOLD_W   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req     = '0;
    bus.pattern = '0;
    bus.hold    = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_src(input int i,
                         input logic [11:0] p,
                         input logic [7:0] h);
    bus.pattern[i*12 +: 12] = p;
    bus.hold[i*8 +: 8]      = h;
  endtask

  function automatic int oh_idx(input logic [3:0] g);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++)
      if (g[i]) r = i;
    return r;
  endfunction

  initial begin
    int   got[6];
    int   n;
    int   cnt;
    int   exp_ord[6];
    logic [3:0] prev;

    exp_ord = '{0, 1, 3, 0, 1, 3};
    for (int k = 0; k < 17; k++) begin
      tv[k].req   = (k >= 2 && k <= 11) ? 4'b0100 : 4'b0000;
      tv[k].pat2  = (k < 5) ? 12'hA5A : 12'h123;
      tv[k].hold2 = (k < 5) ? 8'd3 : 8'd7;
      tv[k].grant = (k >= 2 && k <= 10) ? 4'b0100 : 4'b0000;
      tv[k].led   = (k >= 2 && k <= 10) ? 12'hA5A : 12'h000;
      tv[k].done  = (k == 11) ? 4'b0100 : 4'b0000;
      tv[k].busy  = (k >= 2 && k <= 14);
    end

`ifdef LED_SCHED_PWM_EN
    bus.brightness = 4'hF;
`endif

    // reset state
    do_reset();
    rst = 1'b1;
    step();
    chk("rst.grant", 32'(bus.grant), 0);
    chk("rst.led", 32'(bus.led), 0);
    chk("rst.done", 32'(bus.done), 0);
    chk("rst.busy", 32'(bus.busy), 0);
    rst = 1'b0;

    // single requester, table driven
    for (int k = 0; k < 17; k++) begin
      bus.req = tv[k].req;
      set_src(2, tv[k].pat2, tv[k].hold2);
      step();
      chk($sformatf("A%0d.grant", k), 32'(bus.grant), 32'(tv[k].grant));
      chk($sformatf("A%0d.led", k), 32'(bus.led), 32'(tv[k].led));
      chk($sformatf("A%0d.done", k), 32'(bus.done), 32'(tv[k].done));
      chk($sformatf("A%0d.busy", k), 32'(bus.busy), 32'(tv[k].busy));
    end

    // round-robin with req=1011, hold=1
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 12'h111 * 12'(i + 1), 8'd1);
    bus.req = 4'b1011;
    n = 0;
    prev = '0;
    for (int c = 0; c < 300 && n < 6; c++) begin
      step();
      if (bus.grant != 0 && prev == 0) begin
        got[n] = oh_idx(bus.grant);
        chk($sformatf("B%0d.onehot", n), 32'($countones(bus.grant)), 1);
        chk($sformatf("B%0d.led", n), 32'(bus.led),
            32'(12'h111 * 12'(got[n] + 1)));
        n++;
      end
      prev = bus.grant;
    end
    chk("B.count", 32'(n), 6);
    for (int i = 0; i < n; i++)
      chk($sformatf("B%0d.order", i), 32'(got[i]), 32'(exp_ord[i]));

    // abort two cycles into SHOW
    do_reset();
    set_src(1, 12'h0F0, 8'd5);
    bus.req = 4'b0010;
    step();
    chk("C.grant", 32'(bus.grant), 32'h2);
    step();
    bus.req = 4'b0000;
    step();
    chk("C.ab_grant", 32'(bus.grant), 0);
    chk("C.ab_led", 32'(bus.led), 0);
    chk("C.ab_done", 32'(bus.done), 0);
    chk("C.ab_busy", 32'(bus.busy), 1);
    step();
    chk("C.idle_busy", 32'(bus.busy), 0);
    chk("C.idle_done", 32'(bus.done), 0);

    // abort coinciding with the completion tick
    do_reset();
    set_src(0, 12'hABC, 8'd1);
    bus.req = 4'b0001;
    step();
    chk("D.grant", 32'(bus.grant), 32'h1);
    chk("D.led", 32'(bus.led), 32'hABC);
    step();
    step();
    bus.req = 4'b0000;
    step();
    chk("D.grant0", 32'(bus.grant), 0);
    chk("D.done0", 32'(bus.done), 0);
    chk("D.busy", 32'(bus.busy), 1);
    step();
    step();
    step();
    chk("D.gap_busy", 32'(bus.busy), 1);
    step();
    chk("D.idle_busy", 32'(bus.busy), 0);

    // hold=0 acts as hold=1
    do_reset();
    set_src(0, 12'h555, 8'd0);
    bus.req = 4'b0001;
    step();
    chk("E.grant", 32'(bus.grant), 32'h1);
    step();
    chk("E.done_e2", 32'(bus.done), 0);
    step();
    chk("E.done_e3", 32'(bus.done), 0);
    step();
    chk("E.done_e4", 32'(bus.done), 32'h1);
    chk("E.grant_e4", 32'(bus.grant), 0);
    bus.req = 4'b0000;

    // async reset mid-SHOW, pointer returns to 0
    do_reset();
    set_src(2, 12'h777, 8'd10);
    bus.req = 4'b0100;
    step();
    chk("F.grant", 32'(bus.grant), 32'h4);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("F.rst_grant", 32'(bus.grant), 0);
    chk("F.rst_led", 32'(bus.led), 0);
    chk("F.rst_done", 32'(bus.done), 0);
    chk("F.rst_busy", 32'(bus.busy), 0);
    set_src(3, 12'h888, 8'd2);
    bus.req = 4'b1100;
    #1;
    rst = 1'b0;
    step();
    chk("F.ptr0", 32'(bus.grant), 32'h4);

`ifdef LED_SCHED_PWM_EN
    do_reset();
    set_src(0, 12'hFFF, 8'd255);
    bus.req = 4'b0001;
    bus.brightness = 4'd4;
    step();
    step();
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (bus.led == 12'hFFF) cnt++;
    end
    chk("P.b4", 32'(cnt), 4);
    bus.brightness = 4'd15;
    step();
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (bus.led == 12'hFFF) cnt++;
    end
    chk("P.b15", 32'(cnt), 16);
    bus.brightness = 4'd0;
    step();
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (bus.led != 12'h000) cnt++;
    end
    chk("P.b0", 32'(cnt), 0);
    chk("P.b0_grant", 32'(bus.grant), 32'h1);
    bus.brightness = 4'd15;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
